// File: rtl/mu2cgra_lane_rx.sv
// rtl/mu2cgra_lane_rx.sv - wide beat FIFO fanned out to independent per-lane valid/ready streams
// Optional MU2CGRA_RX_STATS_EN adds beats_rcvd / stall_cycles counters.
module mu2cgra_lane_rx #(
  parameter int LANES = 32,
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         mu2cgra_valid,
  output logic                         cgra2mu_ready,
  input  logic [LANES*WIDTH-1:0]       mu2cgra_dat,
  output logic [LANES-1:0]             lane_valid,
  input  logic [LANES-1:0]             lane_ready,
  output logic [LANES*WIDTH-1:0]       lane_dat,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
`ifdef MU2CGRA_RX_STATS_EN
  ,
  output logic [31:0]                  beats_rcvd,
  output logic [31:0]                  stall_cycles
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [LANES*WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;
  logic [CW-1:0]          count;
  logic [CW-1:0]          count_next;
  logic [LANES-1:0]       done;
  logic [LANES-1:0]       fire;
  logic                   push;
  logic                   retire;
  logic                   nonempty;

  // A lane that fires in the retire cycle completes the beat, so retire looks at done|fire.
  always_comb begin
    nonempty   = (count != '0);
    lane_valid = nonempty ? ~done : '0;
    fire       = lane_valid & lane_ready;
    push       = mu2cgra_valid && cgra2mu_ready;
    retire     = nonempty && (&(done | fire));
    count_next = count;
    if (push && !retire) begin
      count_next = count + CW'(1);
    end else if (!push && retire) begin
      count_next = count - CW'(1);
    end
  end

  assign lane_dat  = mem[rd_ptr];
  assign occupancy = count;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      done          <= '0;
      cgra2mu_ready <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= mu2cgra_dat;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (retire) begin
        rd_ptr <= rd_ptr + PW'(1);
        done   <= '0;
      end else begin
        done <= done | fire;
      end
      count         <= count_next;
      cgra2mu_ready <= (count_next != CW'(DEPTH));
    end
  end

`ifdef MU2CGRA_RX_STATS_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      beats_rcvd   <= '0;
      stall_cycles <= '0;
    end else begin
      if (push && (beats_rcvd != 32'hFFFF_FFFF)) begin
        beats_rcvd <= beats_rcvd + 32'd1;
      end
      if (mu2cgra_valid && !cgra2mu_ready && (stall_cycles != 32'hFFFF_FFFF)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mu2cgra_lane_rx.sv
// tb/tb_mu2cgra_lane_rx.sv - scoreboard bench for mu2cgra_lane_rx
module tb_mu2cgra_lane_rx;

  localparam int LANES = 32;
  localparam int WIDTH = 16;
  localparam int DEPTH = 2;
  localparam int DW    = LANES * WIDTH;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            mu2cgra_valid = 1'b0;
  logic            cgra2mu_ready;
  logic [DW-1:0]   mu2cgra_dat = '0;
  logic [LANES-1:0] lane_valid;
  logic [LANES-1:0] lane_ready = '0;
  logic [DW-1:0]   lane_dat;
  logic [1:0]      occupancy;

  int errors = 0;
  int checks = 0;
  int retired = 0;
  logic [DW-1:0]    exp_q[$];
  logic [LANES-1:0] mon_done = '0;
  logic [DW-1:0]    cur_beat = '0;

  mu2cgra_lane_rx #(.LANES(LANES), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rstn(rstn),
    .mu2cgra_valid(mu2cgra_valid),
    .cgra2mu_ready(cgra2mu_ready),
    .mu2cgra_dat(mu2cgra_dat),
    .lane_valid(lane_valid),
    .lane_ready(lane_ready),
    .lane_dat(lane_dat),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input logic [15:0] base);
    logic [DW-1:0] b;
    for (int i = 0; i < LANES; i++) b[i*WIDTH +: WIDTH] = base + 16'(i);
    return b;
  endfunction

  function automatic logic [DW-1:0] expand(input logic [LANES-1:0] f);
    logic [DW-1:0] m;
    for (int i = 0; i < LANES; i++) m[i*WIDTH +: WIDTH] = f[i] ? '1 : '0;
    return m;
  endfunction

  // Expected beat is queued on the edge that accepts it, so the queue tracks the DUT FIFO.
  task automatic tick();
    logic acc;
    acc = mu2cgra_valid && cgra2mu_ready;
    @(posedge clk);
    if (acc) exp_q.push_back(cur_beat);
    #1;
  endtask

  task automatic offer(input logic [DW-1:0] b);
    cur_beat      = b;
    mu2cgra_dat   = b;
    mu2cgra_valid = 1'b1;
  endtask

  always @(negedge clk) begin
    logic [LANES-1:0] f;
    logic [LANES-1:0] ev;
    if (!rstn) begin
      mon_done = '0;
    end else begin
      ev = (exp_q.size() != 0) ? ~mon_done : '0;
      check("mon_lane_valid", DW'(lane_valid), DW'(ev));
      f = lane_valid & lane_ready;
      if (f != '0) begin
        if (exp_q.size() == 0) begin
          check("mon_fire_on_empty", DW'(f), '0);
        end else begin
          check("mon_lane_dat", lane_dat & expand(f), exp_q[0] & expand(f));
          mon_done = mon_done | f;
          if (&mon_done) begin
            void'(exp_q.pop_front());
            mon_done = '0;
            retired++;
          end
        end
      end
    end
  end

  initial begin
    int r0;
    // reset with arbitrary inputs
    mu2cgra_valid = 1'b1;
    mu2cgra_dat   = mk(16'hBEEF);
    lane_ready    = '1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", DW'(cgra2mu_ready), '0);
    check("rst_lane_valid", DW'(lane_valid), '0);
    check("rst_lane_dat", lane_dat, '0);
    check("rst_occupancy", DW'(occupancy), '0);
    mu2cgra_valid = 1'b0;
    rstn = 1'b1;
    tick();
    check("rst_release_ready", DW'(cgra2mu_ready), DW'(1));

    // single beat, all lanes ready
    offer(mk(16'h0100));
    lane_ready = '1;
    tick();
    mu2cgra_valid = 1'b0;
    check("single_valid", DW'(lane_valid), DW'(32'hFFFF_FFFF));
    check("single_lane5", DW'(lane_dat[5*WIDTH +: WIDTH]), DW'(16'h0105));
    check("single_occ1", DW'(occupancy), DW'(1));
    tick();
    check("single_valid_after", DW'(lane_valid), '0);
    check("single_occ0", DW'(occupancy), '0);

    // staggered lanes
    lane_ready = '0;
    offer(mk(16'h0200));
    tick();
    mu2cgra_valid = 1'b0;
    lane_ready = 32'h0000_FFFF;
    tick();
    check("stag_valid", DW'(lane_valid), DW'(32'hFFFF_0000));
    check("stag_occ1", DW'(occupancy), DW'(1));
    lane_ready = 32'hFFFF_0000;
    tick();
    check("stag_occ0", DW'(occupancy), '0);
    check("stag_valid0", DW'(lane_valid), '0);

    // fill and backpressure
    lane_ready = '0;
    offer(mk(16'hA000));
    tick();
    offer(mk(16'hB000));
    tick();
    check("fill_ready_low", DW'(cgra2mu_ready), '0);
    check("fill_occ2", DW'(occupancy), DW'(2));
    offer(mk(16'hC000));
    tick();
    check("fill_hold_occ", DW'(occupancy), DW'(2));
    check("fill_head_a", lane_dat, mk(16'hA000));
    lane_ready = '1;
    tick();
    check("fill_ready_rise", DW'(cgra2mu_ready), DW'(1));
    check("fill_occ_after_retire", DW'(occupancy), DW'(1));
    check("fill_head_b", lane_dat, mk(16'hB000));
    lane_ready = '0;
    tick();
    mu2cgra_valid = 1'b0;
    check("fill_c_accepted", DW'(occupancy), DW'(2));
    check("fill_head_still_b", lane_dat, mk(16'hB000));
    lane_ready = '1;
    tick();
    tick();
    check("fill_drained", DW'(occupancy), '0);

    // streaming, one beat per cycle
    r0 = retired;
    lane_ready = '1;
    for (int k = 0; k < 8; k++) begin
      offer(mk(16'h1000 + 16'(k * 16'h40)));
      check("stream_ready", DW'(cgra2mu_ready), DW'(1));
      tick();
      check("stream_occ", DW'(occupancy), DW'(1));
    end
    mu2cgra_valid = 1'b0;
    tick();
    check("stream_occ0", DW'(occupancy), '0);
    check("stream_retired", DW'(retired - r0), DW'(8));

    // mid-operation reset
    lane_ready = '0;
    offer(mk(16'h5000));
    tick();
    offer(mk(16'h6000));
    tick();
    mu2cgra_valid = 1'b0;
    lane_ready = 32'h0000_000F;
    tick();
    lane_ready = '0;
    #1;
    rstn = 1'b0;
    exp_q.delete();
    #1;
    check("mrst_occ", DW'(occupancy), '0);
    check("mrst_valid", DW'(lane_valid), '0);
    #5;
    rstn = 1'b1;
    tick();
    check("mrst_ready", DW'(cgra2mu_ready), DW'(1));
    offer(mk(16'h7000));
    tick();
    mu2cgra_valid = 1'b0;
    check("mrst_new_valid", DW'(lane_valid), DW'(32'hFFFF_FFFF));
    check("mrst_new_dat", lane_dat, mk(16'h7000));
    lane_ready = '1;
    tick();
    tick();
    check("end_occ0", DW'(occupancy), '0);
    check("end_queue_empty", DW'(exp_q.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
